// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and instruction decoder for the ALU
// control sequencer.
package alu_pkg;

   // ALU operation codes presented on select_op
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SADD = 4'b0010;
   localparam logic [3:0] ALU_SSUB = 4'b0011;

   // Major opcodes
   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE = 7'b0010011;

   // funct7 / funct3 values of the supported instructions
   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;
   localparam logic [2:0] F3_ADD = 3'b000;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_DECODE    = 2'b01,
      ST_EXECUTE   = 2'b10,
      ST_WRITEBACK = 2'b11
   } state_t;

   // Decoder result
   typedef struct packed {
      logic       legal;
      logic       use_imm;
      logic [3:0] op;
   } decode_t;

   // Classify an instruction from its opcode/funct fields; anything not
   // recognised is reported as illegal.
   function automatic decode_t decode_instr(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic [6:0] funct7);
      decode_t d;
      d.legal   = 1'b0;
      d.use_imm = 1'b0;
      d.op      = ALU_ADD;
      case (opcode)
         OPC_RTYPE: begin
            if ((funct3 == F3_ADD) && (funct7 == F7_ADD)) begin
               d.legal = 1'b1;
               d.op    = ALU_ADD;
            end else if ((funct3 == F3_ADD) && (funct7 == F7_SUB)) begin
               d.legal = 1'b1;
               d.op    = ALU_SUB;
            end else begin
               d.legal = 1'b0;
            end
         end
         OPC_ITYPE: begin
            if (funct3 == F3_ADD) begin
               d.legal   = 1'b1;
               d.use_imm = 1'b1;
               d.op      = ALU_ADD;
            end else begin
               d.legal = 1'b0;
            end
         end
         default: begin
            d.legal = 1'b0;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// I-type immediate generator: sign-extends the 12-bit immediate field to XLEN.
module imm_gen #(
   parameter int XLEN = 32
) (
   input  logic [11:0]     imm12,
   output logic [XLEN-1:0] imm
);

   assign imm = {{(XLEN-12){imm12[11]}}, imm12};

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control sequencer: accepts one ADD/SUB/ADDI per handshake,
// reads the register file, drives the ALU for one execute cycle and writes
// the result back.
module alu_ctrl_fsm
   import alu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           instr,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   output logic [REG_ADDR_W-1:0] rs1_addr,
   output logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [XLEN-1:0]       rs1_data,
   input  logic [XLEN-1:0]       rs2_data,
   output logic [XLEN-1:0]       operand_a,
   output logic [XLEN-1:0]       operand_b,
   output logic [3:0]            select_op,
   input  logic [XLEN-1:0]       result_out,
   output logic                  rd_we,
   output logic [REG_ADDR_W-1:0] rd_addr,
   output logic [XLEN-1:0]       rd_wdata,
   output logic                  done,
   output logic                  illegal_instr
);

   state_t          state_r;
   state_t          next_state_s;
   logic [31:0]     instr_r;
   logic            accept_s;
   decode_t         dec_s;
   logic [XLEN-1:0] imm_s;

   // Register addresses always come from the latched word so a new word on
   // the input bus cannot disturb an instruction in flight.
   assign rs1_addr = REG_ADDR_W'(instr_r[19:15]);
   assign rs2_addr = REG_ADDR_W'(instr_r[24:20]);
   assign rd_addr  = REG_ADDR_W'(instr_r[11:7]);

   assign dec_s = decode_instr(instr_r[6:0], instr_r[14:12], instr_r[31:25]);

   imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .imm12 (instr_r[31:20]),
      .imm   (imm_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic and state-decoded outputs (ready, done, write enable)
   always_comb begin
      next_state_s = state_r;
      instr_ready  = 1'b0;
      accept_s     = 1'b0;
      done         = 1'b0;
      rd_we        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            instr_ready = rst_n;
            if (instr_valid) begin
               accept_s     = 1'b1;
               next_state_s = ST_DECODE;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_DECODE: begin
            if (dec_s.legal) begin
               next_state_s = ST_EXECUTE;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_EXECUTE: begin
            next_state_s = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            done         = 1'b1;
            rd_we        = (rd_addr != {REG_ADDR_W{1'b0}});
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // Instruction latch: loaded only on the accepting handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_r <= 32'h0000_0000;
      end else if (accept_s) begin
         instr_r <= instr;
      end else begin
         instr_r <= instr_r;
      end
   end

   // ALU operand/opcode registers: loaded at the end of a legal decode and
   // held through execute
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         operand_a <= {XLEN{1'b0}};
         operand_b <= {XLEN{1'b0}};
         select_op <= ALU_ADD;
      end else if ((state_r == ST_DECODE) && dec_s.legal) begin
         operand_a <= rs1_data;
         operand_b <= dec_s.use_imm ? imm_s : rs2_data;
         select_op <= dec_s.op;
      end else begin
         operand_a <= operand_a;
         operand_b <= operand_b;
         select_op <= select_op;
      end
   end

   // Result capture at the end of the execute cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_wdata <= {XLEN{1'b0}};
      end else if (state_r == ST_EXECUTE) begin
         rd_wdata <= result_out;
      end else begin
         rd_wdata <= rd_wdata;
      end
   end

   // Illegal-instruction pulse: high for the first idle cycle after a failed decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_instr <= 1'b0;
      end else begin
         illegal_instr <= (state_r == ST_DECODE) && !dec_s.legal;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: timeline model plus directed vectors.
module tb_alu_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [31:0] rs1_data, rs2_data, operand_a, operand_b, result_out, rd_wdata;
   logic [3:0]  select_op;
   logic        rd_we, done, illegal_instr;

   logic [31:0] rf [0:31];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_ctrl_fsm #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .rs1_addr      (rs1_addr),
      .rs2_addr      (rs2_addr),
      .rs1_data      (rs1_data),
      .rs2_data      (rs2_data),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .select_op     (select_op),
      .result_out    (result_out),
      .rd_we         (rd_we),
      .rd_addr       (rd_addr),
      .rd_wdata      (rd_wdata),
      .done          (done),
      .illegal_instr (illegal_instr)
   );

   // Environment: combinational register file and ALU
   assign rs1_data   = rf[rs1_addr];
   assign rs2_data   = rf[rs2_addr];
   assign result_out = (select_op == 4'b0001) ? (operand_a - operand_b) : (operand_a + operand_b);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (instruction timeline) ----------------
   int          cyc = 0;
   bit          inflight = 1'b0;
   int          t_acc = 0;
   bit          m_legal = 1'b0;
   bit [3:0]    m_op = 4'd0;
   bit [31:0]   m_a = 32'd0, m_b = 32'd0, m_res = 32'd0;
   bit [4:0]    m_rd = 5'd0, m_rs1 = 5'd0, m_rs2 = 5'd0;
   bit [31:0]   e_opa = 32'd0, e_opb = 32'd0, e_wdata = 32'd0;
   bit [3:0]    e_sel = 4'd0;

   function automatic bit model_ready();
      return !inflight || ((cyc - t_acc) >= (m_legal ? 4 : 2));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight = 1'b0;
         e_opa = 32'd0; e_opb = 32'd0; e_wdata = 32'd0; e_sel = 4'd0;
      end else begin
         if (instr_valid && model_ready()) begin
            m_rs1 = instr[19:15];
            m_rs2 = instr[24:20];
            m_rd  = instr[11:7];
            m_a   = rf[m_rs1];
            if (instr[6:0] == 7'h33 && instr[14:12] == 3'd0 && instr[31:25] == 7'h00) begin
               m_legal = 1'b1; m_op = 4'd0; m_b = rf[m_rs2]; m_res = m_a + m_b;
            end else if (instr[6:0] == 7'h33 && instr[14:12] == 3'd0 && instr[31:25] == 7'h20) begin
               m_legal = 1'b1; m_op = 4'd1; m_b = rf[m_rs2]; m_res = m_a - m_b;
            end else if (instr[6:0] == 7'h13 && instr[14:12] == 3'd0) begin
               m_legal = 1'b1; m_op = 4'd0; m_b = 32'($signed(instr[31:20])); m_res = m_a + m_b;
            end else begin
               m_legal = 1'b0;
            end
            t_acc    = cyc;
            inflight = 1'b1;
         end
         cyc = cyc + 1;
         if (inflight && m_legal && (cyc - t_acc) == 2) begin
            e_opa = m_a; e_opb = m_b; e_sel = m_op;
         end
         if (inflight && m_legal && (cyc - t_acc) == 3) begin
            e_wdata = m_res;
         end
      end
   end

   // Compare process: every cycle, mid-period
   always @(negedge clk) begin
      int  d;
      bit  wb;
      d  = cyc - t_acc;
      wb = rst_n && inflight && m_legal && (d == 3);
      chk("ready", {31'd0, instr_ready}, {31'd0, rst_n && model_ready()});
      chk("done", {31'd0, done}, {31'd0, wb});
      chk("rd_we", {31'd0, rd_we}, {31'd0, wb && (m_rd != 5'd0)});
      chk("illegal", {31'd0, illegal_instr}, {31'd0, rst_n && inflight && !m_legal && (d == 2)});
      chk("operand_a", operand_a, e_opa);
      chk("operand_b", operand_b, e_opb);
      chk("select_op", {28'd0, select_op}, {28'd0, e_sel});
      chk("rd_wdata", rd_wdata, e_wdata);
      if (rst_n && inflight && d == 1) begin
         chk("rs1_addr", {27'd0, rs1_addr}, {27'd0, m_rs1});
         chk("rs2_addr", {27'd0, rs2_addr}, {27'd0, m_rs2});
      end
      if (wb) begin
         chk("rd_addr", {27'd0, rd_addr}, {27'd0, m_rd});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (instr_ready !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      tests++;
      if (instr_ready !== 1'b1) begin
         fails++;
         $display("FAIL wait_idle: ready %b expected 1 within 10 cycles", instr_ready);
      end
   endtask

   // One-cycle valid pulse; returns at #1 into period t+1
   task automatic issue(input logic [31:0] w);
      wait_idle();
      instr       = w;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      rst_n       = 1'b0;
      instr       = 32'd0;
      instr_valid = 1'b0;
      step();
      chk("rst ready", {31'd0, instr_ready}, 32'd0);
      chk("rst operand_a", operand_a, 32'd0);
      chk("rst select_op", {28'd0, select_op}, 32'd0);
      chk("rst rd_we", {31'd0, rd_we}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst rd_wdata", rd_wdata, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // ADD x3,x1,x2
      issue(32'h002081B3);
      step();
      chk("add sel", {28'd0, select_op}, 32'd0);
      chk("add opb", operand_b, 32'd7);
      step();
      chk("add rd_we", {31'd0, rd_we}, 32'd1);
      chk("add rd_addr", {27'd0, rd_addr}, 32'd3);
      chk("add wdata", rd_wdata, 32'd12);
      chk("add done", {31'd0, done}, 32'd1);

      // SUB x3,x1,x2
      issue(32'h402081B3);
      step();
      chk("sub sel", {28'd0, select_op}, 32'd1);
      step();
      chk("sub wdata", rd_wdata, 32'hFFFF_FFFE);

      // ADDI x5,x1,-1
      rf[1] = 32'd10;
      issue(32'hFFF08293);
      step();
      chk("addi opb", operand_b, 32'hFFFF_FFFF);
      chk("addi opa", operand_a, 32'd10);
      step();
      chk("addi rd_addr", {27'd0, rd_addr}, 32'd5);
      chk("addi wdata", rd_wdata, 32'd9);
      rf[1] = 32'd5;

      // ADD x0,x1,x2: done without write
      issue(32'h00208033);
      step();
      step();
      chk("x0 rd_we", {31'd0, rd_we}, 32'd0);
      chk("x0 done", {31'd0, done}, 32'd1);

      // XOR: illegal
      issue(32'h0020C1B3);
      chk("xor busy", {31'd0, instr_ready}, 32'd0);
      step();
      chk("xor illegal", {31'd0, illegal_instr}, 32'd1);
      chk("xor ready", {31'd0, instr_ready}, 32'd1);
      chk("xor done", {31'd0, done}, 32'd0);
      step();
      chk("xor illegal end", {31'd0, illegal_instr}, 32'd0);

      // Back-to-back with valid held high
      wait_idle();
      instr       = 32'h002081B3;
      instr_valid = 1'b1;
      step();                                   // t+1
      instr = 32'h40208233;                     // SUB x4,x1,x2
      chk("b2b busy", {31'd0, instr_ready}, 32'd0);
      step();                                   // t+2
      step();                                   // t+3
      chk("b2b first rd", {27'd0, rd_addr}, 32'd3);
      chk("b2b first wdata", rd_wdata, 32'd12);
      step();                                   // t+4
      chk("b2b ready t+4", {31'd0, instr_ready}, 32'd1);
      step();                                   // t+5
      instr_valid = 1'b0;
      chk("b2b busy t+5", {31'd0, instr_ready}, 32'd0);
      step();
      step();                                   // t+7
      chk("b2b second rd", {27'd0, rd_addr}, 32'd4);
      chk("b2b second wdata", rd_wdata, 32'hFFFF_FFFE);
      chk("b2b second done", {31'd0, done}, 32'd1);

      // Reset during EXECUTE
      issue(32'h002081B3);
      step();                                   // t+2, EXECUTE
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst ready", {31'd0, instr_ready}, 32'd0);
      chk("mid rst opa", operand_a, 32'd0);
      chk("mid rst opb", operand_b, 32'd0);
      chk("mid rst wdata", rd_wdata, 32'd0);
      chk("mid rst rd_addr", {27'd0, rd_addr}, 32'd0);
      chk("mid rst done", {31'd0, done}, 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("post rst done", {31'd0, done}, 32'd0);
         chk("post rst rd_we", {31'd0, rd_we}, 32'd0);
      end
      issue(32'h002081B3);
      step();
      step();
      chk("recover wdata", rd_wdata, 32'd12);
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
